// File: rtl/inv_round_key_sequencer.sv
// AES-128 decryptor round-key source: forward-expands the cipher key to round NR, then steps keys back down to 0.
// Optional macro INV_KEY_CACHE_EN keeps the last cipher key and its round-NR key so a repeat start skips expansion.
module inv_round_key_sequencer #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         key_valid,
   input  logic         key_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         last
);

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      SERVE
   } state_t;

   localparam logic [3:0] NR_IDX = 4'(NR);

   // AES S-box, byte 0x00 in the most significant position.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   state_t        state;
   state_t        state_next;
   logic [127:0]  work_key;
   logic [3:0]    cnt;
   logic [127:0]  fwd_key;
   logic [127:0]  inv_key;
   logic          cache_match;
   logic          final_accept;

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      logic [10:0] pos;
      pos = 11'd2047 - {b, 3'b000};
      return SBOX_TABLE[pos -: 8];
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0]), sub_byte(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
      logic [7:0] rc;
      case (idx)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'd0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // InvKeyScheduler: undo fwd_step; w3 of the previous round must be recovered before w0.
   function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'd0};
      return {p0, p1, p2, p3};
   endfunction

   assign fwd_key      = fwd_step(work_key, rcon_byte(cnt));
   assign inv_key      = inv_step(work_key, rcon_byte(round_idx));
   assign final_accept = key_ready && (round_idx == 4'd0);

`ifdef INV_KEY_CACHE_EN
   logic [127:0] cache_key;
   logic [127:0] cache_round_key;
   logic         cache_hit;

   assign cache_match = cache_hit && (key_in == cache_key);

   // The key is captured at start with the flag cleared, so the flag only rises once its round-NR key is stored.
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_key       <= '0;
         cache_round_key <= '0;
         cache_hit       <= 1'b0;
      end else begin
         if (state == IDLE && start && !cache_match) begin
            cache_key <= key_in;
            cache_hit <= 1'b0;
         end
         if (state == EXPAND && cnt == NR_IDX) begin
            cache_round_key <= fwd_key;
            cache_hit       <= 1'b1;
         end
      end
   end
`else
   assign cache_match = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = cache_match ? SERVE : EXPAND;
            end
         end
         EXPAND: begin
            if (cnt == NR_IDX) begin
               state_next = SERVE;
            end
         end
         SERVE: begin
            if (final_accept) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      key_valid = (state == SERVE);
      last      = key_valid && (round_idx == 4'd0);
   end

   // Working key, expansion counter and round index; round_key mirrors the working key.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_key  <= '0;
         cnt       <= '0;
         round_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (cache_match) begin
`ifdef INV_KEY_CACHE_EN
                     work_key <= cache_round_key;
`endif
                     round_idx <= NR_IDX;
                  end else begin
                     work_key <= key_in;
                     cnt      <= 4'd1;
                  end
               end
            end
            EXPAND: begin
               work_key <= fwd_key;
               if (cnt == NR_IDX) begin
                  cnt       <= 4'd0;
                  round_idx <= NR_IDX;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            SERVE: begin
               if (key_ready && round_idx != 4'd0) begin
                  work_key  <= inv_key;
                  round_idx <= round_idx - 4'd1;
               end
            end
            default: begin
               cnt <= 4'd0;
            end
         endcase
      end
   end

   assign round_key = work_key;

endmodule
